// File: rtl/spi_regbank_pkg.sv
// spi_regbank_pkg
// Shared definitions for the SPI command decoder / register bank:
//   - op encoding and FSM state enum
//   - header field and status bit positions (within the 8-bit header/status byte)
//   - frame length derivation from the register width
package spi_regbank_pkg;

    localparam int HDR_W     = 8;
    localparam int MAX_WORDS = 4;

    // Header byte fields
    localparam int HDR_OP_LO   = 6;
    localparam int HDR_CNT_LO  = 4;
    localparam int HDR_ADDR_LO = 0;

    // Status byte fields: {fcnt[3:0], op[1:0], ERR, OVR}
    localparam int ST_FCNT_LO = 4;
    localparam int ST_OP_LO   = 2;
    localparam int ST_ERR     = 1;
    localparam int ST_OVR     = 0;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_e;

    function automatic int frame_len(input int dw);
        return HDR_W + MAX_WORDS * dw;
    endfunction

endpackage

// File: rtl/spi_reg_array.sv
// spi_reg_array
// NREG x DW configuration registers with one write port, a whole-bank clear
// and a combinational read port. The bank is also exported flat.
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data   single-register write
//   clr               clears every register (takes priority over a write)
//   rd_addr/rd_data   combinational read
//   reg_out           register k at [k*DW +: DW]
module spi_reg_array #(
    parameter int DW   = 32,
    parameter int NREG = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     wr_en,
    input  logic [$clog2(NREG)-1:0]  wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     clr,
    input  logic [$clog2(NREG)-1:0]  rd_addr,
    output logic [DW-1:0]            rd_data,
    output logic [NREG*DW-1:0]       reg_out
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = regs[rd_addr];

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign reg_out[k*DW +: DW] = regs[k];
    end

endmodule

// File: rtl/spi_cmd_regbank.sv
// spi_cmd_regbank
// Decodes each completed SPI frame (NOP/WRITE/READ/CLEAR), executes it one
// word per cycle against spi_reg_array and loads the response frame for the
// next SPI transaction.
// Ports:
//   CLK, RESET   clock, synchronous active-high reset
//   RXED         frame-complete level from the SPI slave
//   RECEIVED     received frame {header[7:0], word0..word3}
//   TO_SEND      response frame {status[7:0], word0..word3}
//   REG_OUT      flat register contents
//   WR_STB/WR_ADDR   registered write pulse and register index
//   BUSY         high while a frame is being executed
// Build option: SPI_REGBANK_WRAP_EN -- addresses wrap modulo NREG and ERR is
// never raised; otherwise out-of-range words are skipped and flagged as ERR.
module spi_cmd_regbank
    import spi_regbank_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      RXED,
    input  logic [frame_len(DW)-1:0]  RECEIVED,
    output logic [frame_len(DW)-1:0]  TO_SEND,
    output logic [NREG*DW-1:0]        REG_OUT,
    output logic                      WR_STB,
    output logic [3:0]                WR_ADDR,
    output logic                      BUSY
);

    localparam int LENGTH = frame_len(DW);
    localparam int AW     = $clog2(NREG);
    localparam int PW     = MAX_WORDS * DW;

    state_e           state, state_nxt;
    logic             rxed_q;
    logic             rise;
    op_e              op_q;
    logic [1:0]       cnt_q;
    logic [1:0]       idx;
    logic [3:0]       base_q;
    logic [3:0]       fcnt;
    logic [PW-1:0]    payload_q;
    logic [PW-1:0]    resp_q;
    logic             err_q;
    logic             ovr_q;
    logic [HDR_W-1:0] hdr;
    logic [7:0]       status;
    logic [4:0]       addr_full;
    logic [AW-1:0]    addr;
    logic             word_ok;
    logic [1:0]       word_sel;
    logic [DW-1:0]    word_in;
    logic [DW-1:0]    rd_data;
    logic             wr_en;
    logic             clr;

    assign hdr       = RECEIVED[LENGTH-1 -: HDR_W];
    assign rise      = RXED & ~rxed_q;
    assign BUSY      = (state != S_IDLE);
    assign addr_full = {1'b0, base_q} + {3'b000, idx};
    assign addr      = addr_full[AW-1:0];

    // Word 0 is the most significant payload word.
    assign word_sel  = 2'(MAX_WORDS - 1) - idx;
    assign word_in   = payload_q[int'(word_sel)*DW +: DW];

`ifdef SPI_REGBANK_WRAP_EN
    // Truncating addr_full to AW bits already gives (base+i) mod NREG.
    assign word_ok = 1'b1;
`else
    assign word_ok = (addr_full < 5'(NREG));
`endif

    always_comb begin
        status = '0;
        status[ST_FCNT_LO +: 4] = fcnt;
        status[ST_OP_LO +: 2]   = op_q;
        status[ST_ERR]          = err_q;
        status[ST_OVR]          = ovr_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOP and CLEAR ignore the count and finish after a single EXEC cycle.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        clr       = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                wr_en = (op_q == OP_WRITE) && word_ok;
                clr   = (op_q == OP_CLEAR);
                if (op_q == OP_NOP || op_q == OP_CLEAR || idx == cnt_q) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A rise while busy drops that frame; the flag rides on the next response
    // loaded and is cleared by it, unless another drop lands on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxed_q    <= 1'b0;
            op_q      <= OP_NOP;
            cnt_q     <= '0;
            base_q    <= '0;
            payload_q <= '0;
            resp_q    <= '0;
            idx       <= '0;
            fcnt      <= '0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            TO_SEND   <= '0;
            WR_STB    <= 1'b0;
            WR_ADDR   <= '0;
        end else begin
            rxed_q <= RXED;
            WR_STB <= wr_en;
            if (wr_en) begin
                WR_ADDR <= 4'(addr);
            end
            if (rise && BUSY) begin
                ovr_q <= 1'b1;
            end else if (state == S_DONE) begin
                ovr_q <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        op_q      <= op_e'(hdr[HDR_OP_LO +: 2]);
                        cnt_q     <= hdr[HDR_CNT_LO +: 2];
                        base_q    <= hdr[HDR_ADDR_LO +: 4];
                        payload_q <= RECEIVED[PW-1:0];
                        resp_q    <= '0;
                        idx       <= '0;
                        err_q     <= 1'b0;
                        fcnt      <= fcnt + 4'd1;
                    end
                end
                S_EXEC: begin
                    idx <= idx + 2'd1;
                    if (!word_ok) begin
                        err_q <= 1'b1;
                    end
                    if (op_q == OP_READ) begin
                        resp_q[int'(word_sel)*DW +: DW] <= word_ok ? rd_data : '0;
                    end
                end
                S_DONE: begin
                    TO_SEND <= {status, resp_q};
                end
                default: begin
                end
            endcase
        end
    end

    spi_reg_array #(
        .DW   (DW),
        .NREG (NREG)
    ) u_array (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (wr_en),
        .wr_addr (addr),
        .wr_data (word_in),
        .clr     (clr),
        .rd_addr (addr),
        .rd_data (rd_data),
        .reg_out (REG_OUT)
    );

endmodule

// File: tb/tb_spi_cmd_regbank.sv
// tb_spi_cmd_regbank
// Scoreboard bench for spi_cmd_regbank: each frame driven pushes its expected
// response and write strobes; a negedge monitor pops and compares them.
// Honours SPI_REGBANK_WRAP_EN the same way as the design.
module tb_spi_cmd_regbank;

`ifdef SPI_REGBANK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic         CLK;
    logic         RESET;
    logic         RXED;
    logic [135:0] RECEIVED;
    logic [135:0] TO_SEND;
    logic [511:0] REG_OUT;
    logic         WR_STB;
    logic [3:0]   WR_ADDR;
    logic         BUSY;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  model_regs [16];
    logic [3:0]   model_fcnt;
    logic [135:0] resp_exp_q [$];
    logic [35:0]  wr_exp_q [$];
    bit           monitor_on;
    logic         busy_prev;

    spi_cmd_regbank #(.DW(32), .NREG(16)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RXED     (RXED),
        .RECEIVED (RECEIVED),
        .TO_SEND  (TO_SEND),
        .REG_OUT  (REG_OUT),
        .WR_STB   (WR_STB),
        .WR_ADDR  (WR_ADDR),
        .BUSY     (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] modelFlat();
        logic [511:0] f;
        for (int k = 0; k < 16; k++) begin
            f[k*32 +: 32] = model_regs[k];
        end
        return f;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 16; k++) begin
            model_regs[k] = '0;
        end
        model_fcnt = '0;
    endtask

    // Predicts the frame, pushes expectations, then drives it and times it.
    task automatic applyStimulus(input logic [7:0] hdr, input logic [127:0] pay, input bit overrun);
        logic [1:0]   op;
        logic [127:0] resp;
        logic [31:0]  w;
        bit           err;
        int           cnt, base, nexec, a, cycles;
        op    = hdr[7:6];
        cnt   = int'(hdr[5:4]) + 1;
        base  = int'(hdr[3:0]);
        resp  = '0;
        err   = 1'b0;
        nexec = (op == 2'b01 || op == 2'b10) ? cnt : 1;
        model_fcnt = model_fcnt + 4'd1;
        if (op == 2'b01 || op == 2'b10) begin
            for (int i = 0; i < cnt; i++) begin
                a = base + i;
                w = pay[127-32*i -: 32];
                if (a >= 16 && !WRAP) begin
                    err = 1'b1;
                end else begin
                    a = a % 16;
                    if (op == 2'b01) begin
                        model_regs[a] = w;
                        wr_exp_q.push_back({4'(a), w});
                    end else begin
                        resp[127-32*i -: 32] = model_regs[a];
                    end
                end
            end
        end
        if (op == 2'b11) begin
            for (int k = 0; k < 16; k++) begin
                model_regs[k] = '0;
            end
        end
        resp_exp_q.push_back({model_fcnt, op, err, overrun, resp});

        @(negedge CLK);
        RECEIVED = {hdr, pay};
        RXED     = 1'b1;
        @(negedge CLK);
        checkOutput("busy_after_rise", BUSY, 1'b1);
        RXED   = 1'b0;
        cycles = 0;
        while (BUSY && cycles < 20) begin
            @(negedge CLK);
            cycles++;
            if (overrun && cycles == 1) begin
                RECEIVED = {8'h70, {4{32'hDEADBEEF}}};
                RXED     = 1'b1;
            end
            if (overrun && cycles == 2) begin
                RXED = 1'b0;
            end
            if (op == 2'b11 && cycles == 1) begin
                checkOutput("clear_regout", REG_OUT, '0);
            end
        end
        checkOutput("exec_latency", cycles, nexec + 1);
        repeat (2) @(negedge CLK);
        checkOutput("regs_vs_model", REG_OUT, modelFlat());
    endtask

    always @(negedge CLK) begin : monitor
        logic [35:0]  we;
        logic [135:0] re;
        if (monitor_on && !RESET) begin
            if (WR_STB) begin
                if (wr_exp_q.size() == 0) begin
                    checkOutput("wr_unexpected", 1'b1, 1'b0);
                end else begin
                    we = wr_exp_q.pop_front();
                    checkOutput("wr_addr", WR_ADDR, we[35:32]);
                    checkOutput("wr_data", REG_OUT[int'(we[35:32])*32 +: 32], we[31:0]);
                end
            end
            if (busy_prev && !BUSY) begin
                if (resp_exp_q.size() == 0) begin
                    checkOutput("resp_unexpected", 1'b1, 1'b0);
                end else begin
                    re = resp_exp_q.pop_front();
                    checkOutput("to_send", TO_SEND, re);
                end
            end
        end
        busy_prev = BUSY;
    end

    initial begin
        #100000;
        checkOutput("watchdog", 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        RESET      = 1'b1;
        RXED       = 1'b0;
        RECEIVED   = '0;
        monitor_on = 1'b1;
        busy_prev  = 1'b0;
        modelReset();
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        checkOutput("rst_to_send", TO_SEND, '0);
        checkOutput("rst_reg_out", REG_OUT, '0);
        checkOutput("rst_wr_stb", WR_STB, 1'b0);
        checkOutput("rst_wr_addr", WR_ADDR, 4'd0);
        checkOutput("rst_busy", BUSY, 1'b0);

        applyStimulus(8'h73, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 1'b0);
        checkOutput("write_status", TO_SEND[135:128], 8'h14);
        checkOutput("write_reg6", REG_OUT[6*32 +: 32], 32'h44444444);

        applyStimulus(8'h93, 128'h0, 1'b0);
        checkOutput("read_words01", TO_SEND[127:64], 64'h11111111_22222222);
        checkOutput("read_unused", TO_SEND[63:0], 64'h0);
        checkOutput("read_op", TO_SEND[131:130], 2'b10);

        applyStimulus(8'h7E, {32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004}, 1'b0);
        checkOutput("edge_err", TO_SEND[129], !WRAP);
        checkOutput("edge_reg15", REG_OUT[15*32 +: 32], 32'hAAAA0002);

        applyStimulus(8'hBD, 128'h0, 1'b0);
        applyStimulus(8'h00, {4{32'h55555555}}, 1'b0);

        applyStimulus(8'h70, {32'hBBBB0000, 32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003}, 1'b1);
        checkOutput("ovr_set", TO_SEND[128], 1'b1);
        applyStimulus(8'h00, 128'h0, 1'b0);
        checkOutput("ovr_cleared", TO_SEND[128], 1'b0);
        checkOutput("fcnt_after_drop", TO_SEND[135:132], 4'd7);

        applyStimulus(8'hC0, 128'h0, 1'b0);
        checkOutput("clear_op", TO_SEND[131:130], 2'b11);

        monitor_on = 1'b0;
        @(negedge CLK);
        RECEIVED = {8'h73, {32'hCCCC0000, 32'hCCCC0001, 32'hCCCC0002, 32'hCCCC0003}};
        RXED     = 1'b1;
        @(negedge CLK);
        RXED = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("mid_busy", BUSY, 1'b1);
        checkOutput("mid_wr_addr", WR_ADDR, 4'd4);
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("mrst_to_send", TO_SEND, '0);
        checkOutput("mrst_reg_out", REG_OUT, '0);
        checkOutput("mrst_wr_stb", WR_STB, 1'b0);
        checkOutput("mrst_wr_addr", WR_ADDR, 4'd0);
        checkOutput("mrst_busy", BUSY, 1'b0);
        RESET = 1'b0;
        modelReset();
        @(negedge CLK);
        monitor_on = 1'b1;

        applyStimulus(8'h52, {32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0}, 1'b0);
        checkOutput("post_reset_fcnt", TO_SEND[135:132], 4'd1);

        for (int n = 0; n < 15; n++) begin
            applyStimulus(8'h00, 128'h0, 1'b0);
        end
        checkOutput("fcnt_wrap", TO_SEND[135:132], 4'd0);

        checkOutput("resp_q_empty", resp_exp_q.size(), 0);
        checkOutput("wr_q_empty", wr_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
